// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/arb_owner_fifo.sv
// rtl/arb_owner_fifo.sv - in-order 1-bit owner FIFO tracking outstanding transactions
module arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH) + 1;
    // Pointers differ only in the wrap bit when the FIFO is full.
    localparam logic [PW-1:0] WRAP = PW'(1) << (PW - 1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             do_push, do_pop;

    generate
        if (DEPTH > 1) begin : g_idx
            assign wr_idx = wr_ptr_q[IW-1:0];
            assign rd_idx = rd_ptr_q[IW-1:0];
        end else begin : g_idx_single
            assign wr_idx = 1'b0;
            assign rd_idx = 1'b0;
        end
    endgenerate

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == WRAP);
    assign head_o  = mem_q[rd_idx];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_idx] = data_i;
            wr_ptr_d      = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one OBI memory slave between instr and data ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic [6:0]  instr_rdata_intg_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [6:0]  data_rdata_intg_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic [6:0]  mem_rdata_intg_i,
    input  logic        mem_err_i,

    output logic        orphan_o
);

    owner_e last_sel_q, last_sel_d;
    owner_e sel;
    owner_e head_owner;
    logic   orphan_q, orphan_d;
    logic   fifo_full, fifo_empty, head_bit;
    logic   instr_elig, data_elig, accept, pop;

    // Gating with rst keeps every grant low while reset is held, even with requests pending.
    assign instr_elig = instr_req_i & ~fifo_full & rst;
    assign data_elig  = data_req_i  & ~fifo_full & rst;

    always_comb begin
        sel = OWNER_INSTR;
        if (instr_elig && data_elig) begin
            sel = (last_sel_q == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
        end else if (data_elig) begin
            sel = OWNER_DATA;
        end
    end

    assign mem_req_o = instr_elig | data_elig;
    assign accept    = mem_req_o & mem_gnt_i;

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        if (sel == OWNER_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_gnt_o = accept & (sel == OWNER_INSTR);
    assign data_gnt_o  = accept & (sel == OWNER_DATA);

    assign head_owner = owner_e'(head_bit);
    assign pop        = mem_rvalid_i & ~fifo_empty;

    assign instr_rvalid_o     = pop & (head_owner == OWNER_INSTR);
    assign data_rvalid_o      = pop & (head_owner == OWNER_DATA);
    assign instr_rdata_o      = mem_rdata_i;
    assign instr_rdata_intg_o = mem_rdata_intg_i;
    assign instr_err_o        = mem_err_i;
    assign data_rdata_o       = mem_rdata_i;
    assign data_rdata_intg_o  = mem_rdata_intg_i;
    assign data_err_o         = mem_err_i;

    assign last_sel_d = accept ? sel : last_sel_q;
    assign orphan_d   = orphan_q | (mem_rvalid_i & fifo_empty);
    assign orphan_o   = orphan_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_sel_q <= OWNER_DATA;
            orphan_q   <= 1'b0;
        end else begin
            last_sel_q <= last_sel_d;
            orphan_q   <= orphan_d;
        end
    end

    arb_owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .data_i  (logic'(sel)),
        .pop_i   (pop),
        .head_o  (head_bit),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int DEPTH = 2;

    typedef struct {
        logic        data_owner;
        logic [31:0] rdata;
        logic [6:0]  intg;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic [6:0]  instr_rdata_intg_o;
    logic        data_req_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic [6:0]  data_rdata_intg_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [6:0]  mem_rdata_intg_i = '0;
    logic        mem_err_i = 1'b0;
    logic        orphan_o;

    // stimulus knobs
    logic        rst_s = 1'b0, ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dwdata = '0;
    logic [3:0]  dbe = '0;
    logic        sgnt = 1'b0, rv_en = 1'b0, force_orphan = 1'b0, force_err = 1'b0;

    // reference model
    int          outstanding = 0;
    logic        last_data = 1'b1;
    logic        orphan_m = 1'b0;
    logic        slave_resp = 1'b0;
    resp_t       pending[$];
    resp_t       exp_q[$];
    resp_t       mon_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .instr_req_i        (instr_req_i),
        .instr_addr_i       (instr_addr_i),
        .instr_gnt_o        (instr_gnt_o),
        .instr_rvalid_o     (instr_rvalid_o),
        .instr_rdata_o      (instr_rdata_o),
        .instr_rdata_intg_o (instr_rdata_intg_o),
        .instr_err_o        (instr_err_o),
        .data_req_i         (data_req_i),
        .data_addr_i        (data_addr_i),
        .data_we_i          (data_we_i),
        .data_be_i          (data_be_i),
        .data_wdata_i       (data_wdata_i),
        .data_gnt_o         (data_gnt_o),
        .data_rvalid_o      (data_rvalid_o),
        .data_rdata_o       (data_rdata_o),
        .data_rdata_intg_o  (data_rdata_intg_o),
        .data_err_o         (data_err_o),
        .mem_req_o          (mem_req_o),
        .mem_addr_o         (mem_addr_o),
        .mem_we_o           (mem_we_o),
        .mem_be_o           (mem_be_o),
        .mem_wdata_o        (mem_wdata_o),
        .mem_gnt_i          (mem_gnt_i),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_rdata_i        (mem_rdata_i),
        .mem_rdata_intg_i   (mem_rdata_intg_i),
        .mem_err_i          (mem_err_i),
        .orphan_o           (orphan_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at posedge+1, check and advance the model at negedge.
    task automatic step();
        logic  eli, eld, sd, mr;
        resp_t r;
        @(posedge clk);
        #1;
        rst          = rst_s;
        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        data_req_i   = dreq;
        data_addr_i  = daddr;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_wdata_i = dwdata;
        mem_gnt_i    = sgnt;
        mem_rvalid_i = 1'b0;
        slave_resp   = 1'b0;
        if (rst_s) begin
            if (force_orphan) begin
                mem_rvalid_i     = 1'b1;
                mem_rdata_i      = $urandom;
                mem_rdata_intg_i = 7'($urandom);
                mem_err_i        = 1'b0;
            end else if (pending.size() > 0 && rv_en) begin
                r                = pending.pop_front();
                mem_rvalid_i     = 1'b1;
                mem_rdata_i      = r.rdata;
                mem_rdata_intg_i = r.intg;
                mem_err_i        = r.err;
                slave_resp       = 1'b1;
            end
        end
        @(negedge clk);
        if (!rst_s) begin
            chk("reset_outputs", 32'({mem_req_o, instr_gnt_o, data_gnt_o,
                                      instr_rvalid_o, data_rvalid_o, orphan_o}), 32'd0);
            outstanding = 0;
            last_data   = 1'b1;
            orphan_m    = 1'b0;
            pending.delete();
            exp_q.delete();
        end else begin
            eli = ireq && (outstanding < DEPTH);
            eld = dreq && (outstanding < DEPTH);
            sd  = (eli && eld) ? !last_data : eld;
            mr  = eli || eld;
            chk("mem_req", 32'(mem_req_o), 32'(mr));
            chk("instr_gnt", 32'(instr_gnt_o), 32'(mr && !sd && sgnt));
            chk("data_gnt", 32'(data_gnt_o), 32'(mr && sd && sgnt));
            if (mr) begin
                chk("mem_addr", mem_addr_o, sd ? daddr : iaddr);
                chk("mem_we", 32'(mem_we_o), 32'(sd ? dwe : 1'b0));
                chk("mem_be", 32'(mem_be_o), 32'(sd ? dbe : 4'hF));
                chk("mem_wdata", mem_wdata_o, sd ? dwdata : 32'd0);
            end
            chk("orphan", 32'(orphan_o), 32'(orphan_m));
            if (mem_rvalid_i && !slave_resp) orphan_m = 1'b1;
            if (mr && sgnt) begin
                last_data    = sd;
                r.data_owner = sd;
                r.rdata      = $urandom;
                r.intg       = 7'($urandom);
                r.err        = force_err ? 1'b1 : ($urandom_range(0, 7) == 0);
                pending.push_back(r);
                exp_q.push_back(r);
                outstanding++;
            end
            if (slave_resp) outstanding--;
        end
    endtask

    // Response monitor: every presented response is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (slave_resp) begin
                chk("rvalid_present", 32'(instr_rvalid_o | data_rvalid_o), 32'd1);
                chk("rvalid_onehot", 32'(instr_rvalid_o & data_rvalid_o), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: response with no expectation at %0t", $time);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("resp_owner", 32'(data_rvalid_o), 32'(mon_r.data_owner));
                    chk("resp_rdata", mon_r.data_owner ? data_rdata_o : instr_rdata_o, mon_r.rdata);
                    chk("resp_intg", 32'(mon_r.data_owner ? data_rdata_intg_o : instr_rdata_intg_o),
                        32'(mon_r.intg));
                    chk("resp_err", 32'(mon_r.data_owner ? data_err_o : instr_err_o), 32'(mon_r.err));
                end
            end else begin
                chk("spurious_rvalid", 32'(instr_rvalid_o | data_rvalid_o), 32'd0);
            end
        end
    end

    task automatic quiet();
        ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; dbe = '0; dwdata = '0;
        iaddr = '0; daddr = '0; sgnt = 1'b0; rv_en = 1'b1;
        force_orphan = 1'b0; force_err = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_s = 1'b0;
        repeat (n) step();
        rst_s = 1'b1;
    endtask

    initial begin
        quiet();
        do_reset(3);
        repeat (2) step();

        // instruction-only stream, 1-cycle slave
        sgnt = 1'b1; ireq = 1'b1; iaddr = 32'h80;
        step();
        iaddr = 32'h84;
        step();
        ireq = 1'b0;
        repeat (3) step();

        // both sides continuously after reset: INSTR first, then alternate
        do_reset(1);
        ireq = 1'b1; dreq = 1'b1; iaddr = 32'h100; daddr = 32'h200; sgnt = 1'b1;
        repeat (4) step();
        ireq = 1'b0; dreq = 1'b0;
        repeat (3) step();

        // withheld responses fill the owner FIFO, then one pop frees one slot
        rv_en = 1'b0; ireq = 1'b1; dreq = 1'b1;
        repeat (4) step();
        rv_en = 1'b1;
        step();
        rv_en = 1'b0;
        repeat (2) step();
        quiet();
        repeat (4) step();

        // data write with an error response
        dreq = 1'b1; daddr = 32'h1000; dwe = 1'b1; dbe = 4'h3; dwdata = 32'hDEADBEEF;
        sgnt = 1'b1; force_err = 1'b1;
        step();
        quiet();
        repeat (3) step();

        // orphan response with the FIFO drained
        force_orphan = 1'b1;
        step();
        force_orphan = 1'b0;
        repeat (4) step();
        do_reset(1);
        step();

        // reset with one transaction outstanding and both sides requesting
        rv_en = 1'b0; ireq = 1'b1; dreq = 1'b1; sgnt = 1'b1;
        step();
        do_reset(2);
        repeat (3) step();
        quiet();
        repeat (3) step();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            ireq   = ($urandom_range(0, 3) != 0);
            iaddr  = $urandom & 32'hFFFF_FFFC;
            dreq   = ($urandom_range(0, 3) != 0);
            daddr  = $urandom & 32'hFFFF_FFFC;
            dwe    = 1'($urandom);
            dbe    = 4'($urandom);
            dwdata = $urandom;
            sgnt   = ($urandom_range(0, 3) != 0);
            rv_en  = ($urandom_range(0, 2) != 0);
            rst_s  = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_s = 1'b1;
        quiet();
        repeat (DEPTH + 3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester, round-robin arbiter that shares one single-ported, OBI-style memory slave (boot ROM, SRAM) between the core's instruction port and data port. It forwards one granted request per cycle, records which requester owns each outstanding transaction in a small in-order owner FIFO, and routes each response back to its owner. It sits between the Ibex core ports and the memory-side address decoder.

## Interface
- DEPTH, 2: maximum outstanding (granted, not yet responded) transactions; power of two, ≥1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  instruction request
- instr_addr_i  in  32  instruction byte address
- instr_gnt_o  out  1  instruction request accepted this cycle
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  32  instruction read data
- instr_rdata_intg_o  out  7  integrity bits, passed through
- instr_err_o  out  1  instruction response error
- data_req_i  in  1  data request
- data_addr_i  in  32  data byte address
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o  out  1/1/32/7/1  as instruction side
- mem_req_o  out  1  request to slave
- mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  32/1/4/32  muxed request fields
- mem_gnt_i  in  1  slave accepts
- mem_rvalid_i, mem_rdata_i, mem_rdata_intg_i, mem_err_i  in  1/32/7/1  slave response, in order
- orphan_o  out  1  sticky: slave response arrived with owner FIFO empty

## Operation
- Eligible = req_i high and owner FIFO not full. Full blocks new grants even if a pop occurs the same cycle.
- Arbitration: one eligible → select it; both → select the one not selected at last accepted transfer (last_sel). last_sel resets to DATA, so INSTR wins the first tie.
- mem_req_o = any eligible. mem_* fields taken from the selected requester; instr side drives we=0, be=4'hF, wdata=0.
- Selected gnt_o = mem_gnt_i & mem_req_o; other gnt_o = 0. last_sel updates only on mem_req_o & mem_gnt_i.
- Accepted transfer pushes owner bit; mem_rvalid_i pops head. Push and pop in the same cycle are both performed, so occupancy is unchanged.
- Response routing (combinational): owner's rvalid_o = mem_rvalid_i; rdata/intg/err copied to both sides. The non-owner's rvalid_o = 0.
- mem_rvalid_i with empty FIFO: no rvalid_o to either side; orphan_o set, cleared only by reset.
- Request fields are not registered. The requester holds them until gnt, per OBI.

## Timing
- Zero-cycle grant path, req → mem_req_o → gnt_o. Response path is zero-cycle, mem_rvalid_i → owner rvalid_o.
- With a 1-cycle slave: back-to-back requests from one side sustain 1 transfer/cycle when DEPTH ≥ 2.
- Reset values: FIFO empty, last_sel=DATA, orphan_o=0. Comb outputs follow inputs, so all gnt/rvalid are 0 while idle.
- Reset mid-operation discards outstanding ownership. The slave shares the same reset, so no stale responses are expected.
- Wrap-around: FIFO pointers are log2(DEPTH) bits plus an extra wrap bit for the full/empty distinction.

## Structure
- Package mem_arb_pkg: owner_e enum (OWNER_INSTR=1'b0, OWNER_DATA=1'b1), default DEPTH constant.
- Sub-module arb_owner_fifo: DEPTH-entry, 1-bit FIFO with push, pop, head, full and empty. It uses the same clk and rst.

## Test plan
- Instr only, 1-cycle slave, addr 0x80 then 0x84 on consecutive cycles → instr_gnt_o both cycles; instr_rvalid_o in the following cycles, rdata matches the slave; data_rvalid_o stays 0.
- Both sides request continuously for 4 cycles after reset → grant order INSTR, DATA, INSTR, DATA; responses routed to the matching side.
- DEPTH=2, slave withholds rvalid → two grants, then both gnt_o held 0 while req high. One rvalid → exactly one new grant, in the cycle after the pop.
- Data write addr 0x1000, we=1, be=4'h3, wdata=0xDEADBEEF → mem_* fields equal these exactly; data_rvalid_o on response; mem_err_i=1 → data_err_o=1.
- mem_rvalid_i pulsed with FIFO empty → no rvalid_o on either side; orphan_o=1 and stays 1 until rst low.
- Assert rst with 1 outstanding and both requests pending → gnt_o/rvalid_o 0 in reset. After release, FIFO is empty, orphan_o=0, and INSTR wins the first tie.
